// File: rtl/adder_float_pkg.sv
// +--------------------------------------------------------------------------+
// | adder_float_pkg : shared widths, constants and types for adder_float     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package adder_float_pkg;

  localparam int BIT_LENGTH = 16;
  localparam int DATA_W     = 2 * BIT_LENGTH;
  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int BIAS       = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   sig;
  } float_t;

  // Leading-zero count of the 27-bit working significand (27 when all zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_float_fp_add32.sv
// +--------------------------------------------------------------------------+
// | fp_add32 : combinational binary32 adder, round-to-nearest-even           |
// | ADDER_FLOAT_SUBNORMAL_EN selects gradual underflow instead of flushing.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp_add32
  import adder_float_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  function automatic float_t unpack(input logic [31:0] x);
    float_t f;
    f.sign = x[31];
    if (x[30:23] == 8'd0) begin
`ifdef ADDER_FLOAT_SUBNORMAL_EN
      f.exp = 8'd1;
      f.sig = {1'b0, x[22:0]};
`else
      f.exp = 8'd0;
      f.sig = '0;
`endif
    end else begin
      f.exp = x[30:23];
      f.sig = {1'b1, x[22:0]};
    end
    return f;
  endfunction

  float_t       ua, ub, lg, sm;
  logic         a_nan, b_nan, a_inf, b_inf, eff_sub, uflow;
  logic [7:0]   diff;
  logic [53:0]  shifted;
  logic [26:0]  sm_al, norm;
  logic [27:0]  mag;
  logic [4:0]   lz, shamt;
  logic [9:0]   exp_w, exp_n, exp_r;
  logic         round_up;
  logic [24:0]  rsig;
  logic [22:0]  frac_r;
  logic [7:0]   exp_field;

  always_comb begin
    ua      = unpack(a);
    ub      = unpack(b);
    a_nan   = (&a[30:23]) && (|a[22:0]);
    b_nan   = (&b[30:23]) && (|b[22:0]);
    a_inf   = (&a[30:23]) && !(|a[22:0]);
    b_inf   = (&b[30:23]) && !(|b[22:0]);
    eff_sub = a[31] ^ b[31];

    if ({ub.exp, ub.sig} > {ua.exp, ua.sig}) begin
      lg = ub;
      sm = ua;
    end else begin
      lg = ua;
      sm = ub;
    end

    // Alignment keeps guard/round plus a sticky OR of everything shifted out.
    diff    = lg.exp - sm.exp;
    shifted = {sm.sig, 3'b000, 27'd0} >> diff;
    if (diff >= 8'd26) sm_al = {26'd0, |sm.sig};
    else               sm_al = {shifted[53:28], shifted[27] | (|shifted[26:0])};

    if (eff_sub) mag = {1'b0, lg.sig, 3'b000} - {1'b0, sm_al};
    else         mag = {1'b0, lg.sig, 3'b000} + {1'b0, sm_al};

    lz    = lzc27(mag[26:0]);
    exp_w = {2'b00, lg.exp};
    uflow = 1'b0;
    shamt = lz;
    exp_n = exp_w - {5'd0, lz};
    norm  = mag[26:0];
    if (mag[27]) begin
      norm  = {mag[27:2], mag[1] | mag[0]};
      exp_n = exp_w + 10'd1;
    end else begin
`ifdef ADDER_FLOAT_SUBNORMAL_EN
      if ({5'd0, lz} >= exp_w) begin
        shamt = 5'(exp_w - 10'd1);
        exp_n = 10'd1;
      end
`else
      uflow = ({5'd0, lz} >= exp_w);
`endif
      norm = mag[26:0] << shamt;
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rsig     = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (rsig[24]) begin
      frac_r = rsig[23:1];
      exp_r  = exp_n + 10'd1;
    end else begin
      frac_r = rsig[22:0];
      exp_r  = exp_n;
    end
    // A significand without its hidden bit packs as a subnormal.
    exp_field = (rsig[23] | rsig[24]) ? exp_r[7:0] : 8'd0;

    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) y = QNAN;
    else if (a_inf)                                    y = a[31] ? NEG_INF : POS_INF;
    else if (b_inf)                                    y = b[31] ? NEG_INF : POS_INF;
    else if (mag == 28'd0)                             y = {~eff_sub & lg.sign, 31'd0};
    else if (uflow)                                    y = {lg.sign, 31'd0};
    else if (exp_r >= 10'd255)                         y = lg.sign ? NEG_INF : POS_INF;
    else                                               y = {lg.sign, exp_field, frac_r};
  end

endmodule

`default_nettype wire

// File: rtl/adder_float.sv
// +--------------------------------------------------------------------------+
// | adder_float : binary32 accumulator, sum <= sum + addend when Add is set  |
// | Optional macro ADDER_FLOAT_SUBNORMAL_EN enables subnormal support.       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module adder_float
  import adder_float_pkg::*;
#(
  parameter int BIT_LENGTH = adder_float_pkg::BIT_LENGTH
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [2*BIT_LENGTH-1:0] addend,
  input  logic                    Add,
  output logic [2*BIT_LENGTH-1:0] sum
);

  logic [2*BIT_LENGTH-1:0] sum_q, sum_d, add_y;

  fp_add32 u_fp_add32 (
    .a (sum_q),
    .b (addend),
    .y (add_y)
  );

  always_comb begin
    sum_d = sum_q;
    if (Add) sum_d = add_y;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) sum_q <= '0;
    else      sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_float.sv
// +--------------------------------------------------------------------------+
// | tb_adder_float : directed scoreboard bench for adder_float               |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_adder_float;

  logic        Clk;
  logic        Rst;
  logic [31:0] addend;
  logic        Add;
  logic [31:0] sum;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_checks;
  int          n_pass;
  event        sample_ev;

  adder_float dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .addend (addend),
    .Add    (Add),
    .sum    (sum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Monitor: after every rising edge (or on request) compare sum with the oldest expectation.
  always @(posedge Clk or sample_ev) begin
    #2;
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (sum === e) n_pass++;
      else $display("FAIL %s: sum=%08h expected=%08h", nm, sum, e);
    end
  end

  task automatic cycle(input logic add, input logic [31:0] val,
                       input logic [31:0] e, input string nm);
    @(negedge Clk);
    Add    = add;
    addend = val;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Assert reset between edges, check it acts at once and holds through an edge with Add=1.
  task automatic do_reset(input string nm);
    @(negedge Clk);
    #1;
    Rst    = 1'b0;
    Add    = 1'b1;
    addend = 32'h3F80_0000;
    #1;
    exp_q.push_back(32'h0);
    name_q.push_back({nm, "_immediate"});
    ->sample_ev;
    @(negedge Clk);
    exp_q.push_back(32'h0);
    name_q.push_back({nm, "_hold"});
    @(negedge Clk);
    Rst = 1'b1;
    Add = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Rst      = 1'b0;
    Add      = 1'b0;
    addend   = 32'h0;
    #23;
    exp_q.push_back(32'h0);
    name_q.push_back("reset_state");
    ->sample_ev;
    @(negedge Clk);
    Rst = 1'b1;

    cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, "acc_1p0");
    cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, "acc_2p0");
    cycle(1'b1, 32'hBF80_0000, 32'h3F80_0000, "sub_to_1p0");
    cycle(1'b1, 32'hBF80_0000, 32'h0000_0000, "cancel_pos_zero");
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h3F80_0000, 32'h0000_0000, "hold_add0");
    cycle(1'b1, 32'h4040_0000, 32'h4040_0000, "load_3p0");
    cycle(1'b0, 32'h0, 32'h4040_0000, "hold_3p0");
    do_reset("midrun_rst");
    cycle(1'b1, 32'h0000_0000, 32'h0000_0000, "after_release");

`ifdef ADDER_FLOAT_SUBNORMAL_EN
    cycle(1'b1, 32'h0000_004B, 32'h0000_004B, "subnorm_first");
    cycle(1'b1, 32'h0000_0051, 32'h0000_009C, "subnorm_second");
`else
    cycle(1'b1, 32'h0000_004B, 32'h0000_0000, "subnorm_first");
    cycle(1'b1, 32'h0000_0051, 32'h0000_0000, "subnorm_second");
`endif

    do_reset("rst_inf");
    cycle(1'b1, 32'h7F80_0000, 32'h7F80_0000, "load_pinf");
    cycle(1'b1, 32'hFF80_0000, 32'h7FC0_0000, "inf_minus_inf");
    cycle(1'b1, 32'h3F80_0000, 32'h7FC0_0000, "nan_propagates");

    do_reset("rst_ovf");
    cycle(1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, "load_max");
    cycle(1'b1, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow_pinf");

    do_reset("rst_novf");
    cycle(1'b1, 32'hFF7F_FFFF, 32'hFF7F_FFFF, "load_negmax");
    cycle(1'b1, 32'hFF7F_FFFF, 32'hFF80_0000, "overflow_ninf");

    do_reset("rst_tie");
    cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, "tie_load");
    cycle(1'b1, 32'h3380_0000, 32'h3F80_0000, "tie_to_even_down");

    do_reset("rst_tie_up");
    cycle(1'b1, 32'h3F80_0001, 32'h3F80_0001, "tie_up_load");
    cycle(1'b1, 32'h3380_0000, 32'h3F80_0002, "tie_to_even_up");

    do_reset("rst_misc");
    cycle(1'b1, 32'h3FC0_0000, 32'h3FC0_0000, "load_1p5");
    cycle(1'b1, 32'h4010_0000, 32'h4070_0000, "add_2p25");
    cycle(1'b1, 32'hC070_0000, 32'h0000_0000, "cancel_3p75");
    cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, "reload_1p0");
    cycle(1'b1, 32'hBF40_0000, 32'h3E80_0000, "sub_normalize");
    cycle(1'b1, 32'h3E80_0000, 32'h3F00_0000, "add_quarter");
    cycle(1'b1, 32'h3F00_0000, 32'h3F80_0000, "add_half");
    cycle(1'b1, 32'h3080_0000, 32'h3F80_0000, "far_add_sticky");
    cycle(1'b1, 32'hB080_0000, 32'h3F80_0000, "far_sub_roundup");
    cycle(1'b1, 32'h8000_0000, 32'h3F80_0000, "add_neg_zero");
    cycle(1'b0, 32'h0, 32'h3F80_0000, "final_hold");

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
        @(posedge Clk);
        budget++;
      end
      #3;
      if (exp_q.size() > 0) begin
        n_checks++;
        $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim_time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
